// File: rtl/crono_ctrl_if.sv
// Control/display bundle between push-button logic and the stopwatch core.
interface crono_ctrl_if #(
  parameter int unsigned DIGITS = 4
);
  logic                  start;
  logic                  stop;
  logic                  clear;
  logic                  lap;
  logic [4*DIGITS-1:0]   bcd_out;
  logic                  running;
  logic                  tick;
  logic                  overflow;
  logic                  lap_frozen;

  modport master (
    output start, stop, clear, lap,
    input  bcd_out, running, tick, overflow, lap_frozen
  );

  modport slave (
    input  start, stop, clear, lap,
    output bcd_out, running, tick, overflow, lap_frozen
  );
endinterface

// File: rtl/crono_ctrl.sv
// Stopwatch controller: prescaler, start/stop/clear FSM, BCD digit cascade,
// overflow flag and lap-freeze display. Optional macro: CRONO_SATURATE_EN.
module crono_ctrl #(
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned PRESCALE = 10,
  parameter int unsigned PW       = 4
) (
  input  logic        clk,
  input  logic        rst,
  crono_ctrl_if.slave bus
);

  localparam int unsigned BW = 4 * DIGITS;
  localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [BW-1:0]   digits_q, digits_d;
  logic [BW-1:0]   disp_q, disp_d;
  logic            tick_q, tick_d;
  logic            ovf_q, ovf_d;
  logic            frozen_q, frozen_d;
  logic            running_q, running_d;
`ifdef CRONO_SATURATE_EN
  logic            sat_q, sat_d;
`endif

  logic            period_end_c;
  logic            wrap_c;
  logic            resume_ok_c;
  logic [BW-1:0]   digits_inc_c;

  assign period_end_c = (state_q == S_RUN) && (presc_q == PRESC_MAX);

`ifdef CRONO_SATURATE_EN
  assign resume_ok_c = !sat_q;
`else
  assign resume_ok_c = 1'b1;
`endif

  // Carry ripples through digits combinationally so all digits update on one edge.
  always_comb begin
    logic carry;
    digits_inc_c = digits_q;
    carry        = 1'b1;
    for (int k = 0; k < int'(DIGITS); k++) begin
      if (carry) begin
        if (digits_q[4*k +: 4] == 4'd9) begin
          digits_inc_c[4*k +: 4] = 4'd0;
        end else begin
          digits_inc_c[4*k +: 4] = digits_q[4*k +: 4] + 4'd1;
          carry                  = 1'b0;
        end
      end
    end
    wrap_c = carry;
  end

  always_comb begin
    state_d  = state_q;
    presc_d  = presc_q;
    digits_d = digits_q;
    tick_d   = 1'b0;
    ovf_d    = ovf_q;
    frozen_d = frozen_q;
`ifdef CRONO_SATURATE_EN
    sat_d    = sat_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) state_d = S_RUN;
      end
      S_RUN: begin
        if (bus.stop) state_d = S_PAUSE;
        if (bus.lap)  frozen_d = !frozen_q;
      end
      S_PAUSE: begin
        if (bus.start && resume_ok_c) state_d = S_RUN;
        if (bus.lap) frozen_d = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase

    if (state_q == S_RUN) begin
      presc_d = period_end_c ? '0 : presc_q + PW'(1);
    end

    // Count advance; the registered state lets a same-edge stop keep this tick.
    if (period_end_c) begin
`ifdef CRONO_SATURATE_EN
      if (wrap_c) begin
        ovf_d   = 1'b1;
        sat_d   = 1'b1;
        state_d = S_PAUSE;
      end else begin
        digits_d = digits_inc_c;
        tick_d   = 1'b1;
      end
`else
      digits_d = digits_inc_c;
      tick_d   = 1'b1;
      if (wrap_c) ovf_d = 1'b1;
`endif
    end

    if (bus.clear) begin
      state_d  = S_IDLE;
      presc_d  = '0;
      digits_d = '0;
      tick_d   = 1'b0;
      ovf_d    = 1'b0;
      frozen_d = 1'b0;
`ifdef CRONO_SATURATE_EN
      sat_d    = 1'b0;
`endif
    end

    // Unfrozen display mirrors the digits; freezing keeps what is already shown.
    disp_d    = frozen_d ? disp_q : digits_d;
    running_d = (state_d == S_RUN);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      presc_q   <= '0;
      digits_q  <= '0;
      disp_q    <= '0;
      tick_q    <= 1'b0;
      ovf_q     <= 1'b0;
      frozen_q  <= 1'b0;
      running_q <= 1'b0;
`ifdef CRONO_SATURATE_EN
      sat_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      digits_q  <= digits_d;
      disp_q    <= disp_d;
      tick_q    <= tick_d;
      ovf_q     <= ovf_d;
      frozen_q  <= frozen_d;
      running_q <= running_d;
`ifdef CRONO_SATURATE_EN
      sat_q     <= sat_d;
`endif
    end
  end

  assign bus.bcd_out    = disp_q;
  assign bus.running    = running_q;
  assign bus.tick       = tick_q;
  assign bus.overflow   = ovf_q;
  assign bus.lap_frozen = frozen_q;

endmodule

// File: tb/tb_crono_ctrl.sv
// Directed bench for crono_ctrl with DIGITS=2, PRESCALE=3.
module tb_crono_ctrl;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  crono_ctrl_if #(.DIGITS(2)) bus ();

  crono_ctrl #(
    .DIGITS  (2),
    .PRESCALE(3),
    .PW      (2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One-cycle pulse, v = {clear, stop, start, lap}; returns at the following negedge.
  task automatic pulse(input logic [3:0] v);
    bus.clear = v[3];
    bus.stop  = v[2];
    bus.start = v[1];
    bus.lap   = v[0];
    @(negedge clk);
    bus.clear = 1'b0;
    bus.stop  = 1'b0;
    bus.start = 1'b0;
    bus.lap   = 1'b0;
  endtask

  task automatic chk_all(input string tag, input logic [7:0] bcd, input logic run_e,
                         input logic tck, input logic ovf, input logic frz);
    chk({tag, "_bcd"},  32'(bus.bcd_out),    32'(bcd));
    chk({tag, "_run"},  32'(bus.running),    32'(run_e));
    chk({tag, "_tick"}, 32'(bus.tick),       32'(tck));
    chk({tag, "_ovf"},  32'(bus.overflow),   32'(ovf));
    chk({tag, "_frz"},  32'(bus.lap_frozen), 32'(frz));
  endtask

  localparam logic [3:0] P_CLEAR = 4'b1000;
  localparam logic [3:0] P_STOP  = 4'b0100;
  localparam logic [3:0] P_START = 4'b0010;
  localparam logic [3:0] P_LAP   = 4'b0001;

  initial begin
    logic any_tick;
    total     = 0;
    bad       = 0;
    rst       = 1'b0;
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    bus.clear = 1'b0;
    bus.lap   = 1'b0;

    run(3);
    chk_all("reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;

    // Tick cadence and first carry into digit 1
    pulse(P_START);
    chk_all("start", 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 30; i++) begin
      run(1);
      chk("cadence_tick", 32'(bus.tick), 32'((i % 3) == 0));
    end
    chk("ten_ticks_bcd", 32'(bus.bcd_out), 32'h10);
    chk("ten_ticks_run", 32'(bus.running), 32'd1);

    // Pause keeps the partial prescaler period
    pulse(P_CLEAR);
    chk_all("clear1", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    pulse(P_START);
    run(15);
    chk("five_bcd", 32'(bus.bcd_out), 32'h05);
    run(1);
    pulse(P_STOP);
    any_tick = 1'b0;
    for (int i = 0; i < 20; i++) begin
      run(1);
      any_tick |= bus.tick;
    end
    chk_all("paused", 8'h05, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("pause_no_tick", 32'(any_tick), 32'd0);
    pulse(P_START);
    chk_all("resume", 8'h05, 1'b1, 1'b0, 1'b0, 1'b0);
    run(1);
    chk_all("resume_tick", 8'h06, 1'b1, 1'b1, 1'b0, 1'b0);

    // Full scale
    run(279);
    chk_all("at_99", 8'h99, 1'b1, 1'b1, 1'b0, 1'b0);
    run(3);
`ifdef CRONO_SATURATE_EN
    chk_all("sat", 8'h99, 1'b0, 1'b0, 1'b1, 1'b0);
    pulse(P_START);
    chk_all("sat_start", 8'h99, 1'b0, 1'b0, 1'b1, 1'b0);
    run(6);
    chk_all("sat_hold", 8'h99, 1'b0, 1'b0, 1'b1, 1'b0);
`else
    chk_all("wrap", 8'h00, 1'b1, 1'b1, 1'b1, 1'b0);
    run(3);
    chk_all("sticky_ovf", 8'h01, 1'b1, 1'b1, 1'b1, 1'b0);
`endif
    pulse(P_CLEAR);
    chk_all("clear2", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

    // Lap freeze and release
    pulse(P_LAP);
    chk("idle_lap_frz", 32'(bus.lap_frozen), 32'd0);
    pulse(P_START);
    run(36);
    chk("twelve_bcd", 32'(bus.bcd_out), 32'h12);
    pulse(P_LAP);
    chk_all("lap_on", 8'h12, 1'b1, 1'b0, 1'b0, 1'b1);
    run(17);
    chk_all("lap_hold", 8'h12, 1'b1, 1'b1, 1'b0, 1'b1);
    pulse(P_LAP);
    chk_all("lap_off", 8'h18, 1'b1, 1'b0, 1'b0, 1'b0);
    pulse(P_LAP);
    chk_all("lap_on2", 8'h18, 1'b1, 1'b0, 1'b0, 1'b1);
    pulse(P_STOP);
    chk_all("stop_on_tick", 8'h18, 1'b0, 1'b1, 1'b0, 1'b1);
    pulse(P_LAP);
    chk_all("pause_release", 8'h19, 1'b0, 1'b0, 1'b0, 1'b0);
    pulse(P_LAP);
    chk("pause_lap_noop", 32'(bus.lap_frozen), 32'd0);

    // clear beats stop/start on a tick edge
    pulse(P_START);
    chk("resume2_run", 32'(bus.running), 32'd1);
    run(2);
    pulse(P_CLEAR | P_STOP | P_START);
    chk_all("csx", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset mid-run while frozen
    pulse(P_START);
    run(4);
    pulse(P_LAP);
    run(1);
    chk_all("pre_rst", 8'h01, 1'b1, 1'b1, 1'b0, 1'b1);
    rst = 1'b0;
    run(1);
    chk_all("mid_rst", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    pulse(P_START);
    chk_all("post_rst", 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    run(3);
    chk_all("post_rst_tick", 8'h01, 1'b1, 1'b1, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
